uart_rx_fifo: RTL

//  Receive-side buffer placed directly downstream of the uart receiver.

---
 rtl/uart_rx_fifo_pkg.sv | 14 +
 rtl/uart_rx_fifo_regfile.sv | 30 +++
 rtl/uart_rx_fifo.sv | 119 +++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared helpers for the uart receive-side FIFO.
package uart_rx_fifo_pkg;

    // Ceiling log2 for sizing pointers and counters; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_regfile.sv
// Depth x W storage array: synchronous write, asynchronous read.
module fifo_regfile
    import uart_rx_fifo_pkg::*;
#(
    parameter int W     = 9,
    parameter int Depth = 16
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(Depth)-1:0]   waddr,
    input  logic [W-1:0]              wdata,
    input  logic [clog2(Depth)-1:0]   raddr,
    output logic [W-1:0]              rdata
);

    logic [W-1:0] mem [Depth];

    // Write port; contents are not reset, occupancy is tracked by the controller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Show-ahead read of the addressed entry.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the uart: buffers {err,word} on rx_done, presents
// the head on valid/ready, and throttles the uart through rx_enable.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DataBits   = 8,
    parameter int Depth      = 16,
    parameter int Headroom   = 1,
    parameter bit DropErrors = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    output logic                         rx_enable,
    input  logic [DataBits-1:0]          rx_word,
    input  logic                         rx_error,
    input  logic                         rx_done,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DataBits-1:0]          m_data,
    output logic                         m_err,
    output logic [clog2(Depth+1)-1:0]    level,
    output logic                         overflow,
    output logic [7:0]                   err_count,
    input  logic                         clear_status
);

    localparam int AW = clog2(Depth);
    localparam int CW = clog2(Depth + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(Depth);
    localparam logic [CW-1:0] HEAD_C  = CW'(Headroom);
    localparam logic [AW-1:0] LAST_C  = AW'(Depth - 1);

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic                push;
    logic                pop;
    logic                full;
    logic                accept;
    logic                err_event;
    logic [DataBits:0]   head;

    // Push/pop qualification; a full FIFO only takes a word when it also pops.
    always_comb begin
        push      = rx_done & ~(DropErrors & rx_error);
        pop       = (count != '0) & m_ready;
        full      = (count == DEPTH_C);
        accept    = push & (~full | pop);
        err_event = rx_done & rx_error;
    end

    fifo_regfile #(
        .W     (DataBits + 1),
        .Depth (Depth)
    ) u_regfile (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr),
        .wdata ({rx_error, rx_word}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointer and occupancy tracking; pointers wrap at Depth-1 so any depth works.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + AW'(1);
            end
            if (accept && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !accept) begin
                count <= count - CW'(1);
            end
        end
    end

    // Sticky status; a set in the same cycle as clear_status wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (clear_status) begin
                overflow <= 1'b0;
            end
            if (err_event) begin
                if (clear_status) begin
                    err_count <= 8'd1;
                end else if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (clear_status) begin
                err_count <= '0;
            end
        end
    end

    // Consumer view and uart throttle; head is masked to zero while empty and
    // rx_enable depends only on the count register, never on m_ready.
    always_comb begin
        m_valid   = (count != '0);
        m_data    = m_valid ? head[DataBits-1:0] : '0;
        m_err     = m_valid ? head[DataBits] : 1'b0;
        level     = count;
        rx_enable = enable & ~reset & ((DEPTH_C - count) > HEAD_C);
    end

endmodule
